// File: rtl/ssr_sequencer.sv
// Single-shot-readout sequencer: clear, alternating swap/gate windows, readout, resync of the flip decision.
// Optional SSR_FLIP_COUNT_EN adds a saturating count of done pulses that reported a flip.
module ssr_sequencer #(
    parameter int N_REP_W   = 16,
    parameter int WIN_W     = 16,
    parameter int PULSE_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [N_REP_W-1:0] n_rep,
    input  logic [WIN_W-1:0]   window_len,
    input  logic               flip_in,
    output logic               ssr,
    output logic               flip_clr,
    output logic               swap,
    output logic               gate,
    output logic               readout,
    output logic               busy,
    output logic               done,
    output logic               result
`ifdef SSR_FLIP_COUNT_EN
    ,
    input  logic               flip_count_clr,
    output logic [15:0]        flip_count
`endif
);

    typedef enum logic [2:0] {IDLE, CLEAR, SWAP, WINDOW, READOUT, WAIT} state_t;

    localparam logic [3:0]         PL_LAST  = 4'(PULSE_LEN - 1);
    localparam logic [3:0]         WAIT_LAST = 4'd2;
    localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
    localparam logic [N_REP_W:0]   REP_ONE  = (N_REP_W+1)'(1);

    state_t             state, state_nxt;
    logic [3:0]         scnt, scnt_nxt;
    logic [WIN_W-1:0]   wcnt, wcnt_nxt, win_q, win_nxt;
    logic [N_REP_W:0]   rcnt, rcnt_nxt, rcnt_inc;
    logic [N_REP_W-1:0] nrep_q, nrep_nxt;
    logic               half, half_nxt;
    logic               sync1, sync2;
    logic               kill, wrap_up;

    assign kill     = abort && (state != IDLE);
    // Outputs lag the state by one cycle, so IDLE with busy still high marks the WAIT exit.
    assign wrap_up  = (state == IDLE) && busy;
    assign rcnt_inc = rcnt + REP_ONE;

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        wcnt_nxt  = wcnt;
        rcnt_nxt  = rcnt;
        half_nxt  = half;
        nrep_nxt  = nrep_q;
        win_nxt   = win_q;
        if (kill) begin
            state_nxt = IDLE;
            scnt_nxt  = '0;
            wcnt_nxt  = '0;
            rcnt_nxt  = '0;
            half_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !busy) begin
                    nrep_nxt  = n_rep;
                    win_nxt   = (window_len == '0) ? WIN_ONE : window_len;
                    scnt_nxt  = '0;
                    wcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                    half_nxt  = 1'b0;
                    state_nxt = CLEAR;
                end
                CLEAR: if (scnt == PL_LAST) begin
                    scnt_nxt  = '0;
                    state_nxt = (nrep_q != '0) ? SWAP : READOUT;
                end else begin
                    scnt_nxt = scnt + 4'd1;
                end
                SWAP: begin
                    wcnt_nxt  = '0;
                    state_nxt = WINDOW;
                end
                WINDOW: if (wcnt == win_q - WIN_ONE) begin
                    half_nxt = ~half;
                    if (!half) begin
                        state_nxt = SWAP;
                    end else begin
                        rcnt_nxt  = rcnt_inc;
                        state_nxt = (rcnt_inc < {1'b0, nrep_q}) ? SWAP : READOUT;
                    end
                end else begin
                    wcnt_nxt = wcnt + WIN_ONE;
                end
                READOUT: if (scnt == PL_LAST) begin
                    scnt_nxt  = '0;
                    state_nxt = WAIT;
                end else begin
                    scnt_nxt = scnt + 4'd1;
                end
                WAIT: if (scnt == WAIT_LAST) begin
                    scnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    scnt_nxt = scnt + 4'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            scnt   <= '0;
            wcnt   <= '0;
            rcnt   <= '0;
            half   <= 1'b0;
            nrep_q <= '0;
            win_q  <= '0;
        end else begin
            state  <= state_nxt;
            scnt   <= scnt_nxt;
            wcnt   <= wcnt_nxt;
            rcnt   <= rcnt_nxt;
            half   <= half_nxt;
            nrep_q <= nrep_nxt;
            win_q  <= win_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= flip_in;
            sync2 <= sync1;
        end
    end

    // Abort clears the strobes on the same edge the FSM drops to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssr      <= 1'b0;
            flip_clr <= 1'b0;
            swap     <= 1'b0;
            gate     <= 1'b0;
            readout  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 1'b0;
        end else if (kill) begin
            ssr      <= 1'b0;
            flip_clr <= 1'b0;
            swap     <= 1'b0;
            gate     <= 1'b0;
            readout  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ssr      <= (state == CLEAR);
            flip_clr <= (state == CLEAR);
            swap     <= (state == SWAP);
            gate     <= (state == WINDOW);
            readout  <= (state == READOUT);
            busy     <= (state != IDLE);
            done     <= wrap_up;
            if (wrap_up) result <= sync2;
        end
    end

`ifdef SSR_FLIP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flip_count <= '0;
        else if (flip_count_clr)
            flip_count <= '0;
        else if (wrap_up && sync2 && (flip_count != 16'hFFFF))
            flip_count <= flip_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ssr_sequencer.sv
// Randomised self-checking bench for ssr_sequencer; expected strobes come from the closed-form cycle timeline.
// Build with SSR_FLIP_COUNT_EN defined to also exercise the flip counter.
module tb_ssr_sequencer;

    localparam int P   = 4;
    localparam int NRW = 3;
    localparam int WW  = 4;

    logic           clk, reset, start, abort, flip_in;
    logic [NRW-1:0] n_rep;
    logic [WW-1:0]  window_len;
    logic           ssr, flip_clr, swap, gate, readout, busy, done, result;
`ifdef SSR_FLIP_COUNT_EN
    logic           flip_count_clr;
    logic [15:0]    flip_count;
`endif

    int errors = 0;
    int checks = 0;
    bit prev_result = 1'b0;

    ssr_sequencer #(.N_REP_W(NRW), .WIN_W(WW), .PULSE_LEN(P)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_rep(n_rep), .window_len(window_len), .flip_in(flip_in),
        .ssr(ssr), .flip_clr(flip_clr), .swap(swap), .gate(gate),
        .readout(readout), .busy(busy), .done(done), .result(result)
`ifdef SSR_FLIP_COUNT_EN
        , .flip_count_clr(flip_count_clr), .flip_count(flip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One measurement. Cycle k is the cycle after edge k; start is accepted at edge 0.
    task automatic run_seq(input int n, input int w, input bit flip, input bit noise,
                           input int abort_at, input int clr_at);
        int weff, per, t_end, last;
        logic [6:0] exp_v, obs_v;
        logic exp_res;
        weff  = (w == 0) ? 1 : w;
        per   = 1 + weff;
        t_end = P + 2 * n * per;
        last  = t_end + P + 4;
        @(posedge clk); #1;
        start = 1'b1; n_rep = NRW'(n); window_len = WW'(w); flip_in = flip;
        @(posedge clk);
        for (int k = 0; k <= last + 1; k++) begin
            #1;
            start = (noise && abort_at < 0 && k <= last - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort = (k == abort_at);
`ifdef SSR_FLIP_COUNT_EN
            flip_count_clr = (k == clr_at);
`endif
            @(negedge clk);
            if (k >= 1) begin
                exp_v = '0;
                if (abort_at < 0 || k <= abort_at) begin
                    if (k <= P) exp_v[6:5] = 2'b11;
                    if (k > P && k <= t_end) begin
                        if ((k - P - 1) % per == 0) exp_v[4] = 1'b1;
                        else                        exp_v[3] = 1'b1;
                    end
                    if (k > t_end && k <= t_end + P) exp_v[2] = 1'b1;
                    if (k <= t_end + P + 3)          exp_v[1] = 1'b1;
                    if (k == last)                   exp_v[0] = 1'b1;
                end
                obs_v = {ssr, flip_clr, swap, gate, readout, busy, done};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL strobes n=%0d w=%0d cycle %0d: got %b expected %b (ssr,flip_clr,swap,gate,readout,busy,done)",
                             n, w, k, obs_v, exp_v);
                end
                exp_res = (abort_at < 0 && k >= last) ? flip : prev_result;
                checks++;
                if (result !== exp_res) begin
                    errors++;
                    $display("FAIL result n=%0d w=%0d cycle %0d: got %b expected %b", n, w, k, result, exp_res);
                end
            end
            @(posedge clk);
        end
        #1;
        start = 1'b0; abort = 1'b0;
`ifdef SSR_FLIP_COUNT_EN
        flip_count_clr = 1'b0;
`endif
        if (abort_at < 0) prev_result = flip;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        prev_result = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        flip_in = 1'b1;
        do_reset();
        checks++;
        if ({ssr, flip_clr, swap, gate, readout, busy, done, result} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {ssr, flip_clr, swap, gate, readout, busy, done, result});
        end
    endtask

    task automatic test_directed();
        run_seq(2, 3, 1'b1, 1'b0, -1, -1);
        run_seq(0, 5, 1'b0, 1'b0, -1, -1);
        run_seq(1, 0, 1'b1, 1'b0, -1, -1);
        run_seq(7, 1, 1'b0, 1'b1, -1, -1);
    endtask

    task automatic test_abort();
        run_seq(2, 3, 1'b0, 1'b0, -1, -1);
        run_seq(2, 3, 1'b1, 1'b0, 10, -1);
        run_seq(2, 3, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_async_reset();
        run_seq(0, 1, 1'b1, 1'b0, -1, -1);
        @(posedge clk); #1;
        start = 1'b1; n_rep = '0; window_len = WW'(5); flip_in = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (readout !== 1'b1) begin
            errors++;
            $display("FAIL readout_before_reset: got %b expected 1", readout);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({readout, busy, result} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_drop: got %b expected 000 (readout,busy,result)", {readout, busy, result});
        end
        @(posedge clk); #3 reset = 1'b0;
        prev_result = 1'b0;
        @(negedge clk);
        checks++;
        if ({ssr, swap, gate, readout, busy, done, result} !== 7'b0) begin
            errors++;
            $display("FAIL after_reset_release: got %b expected 0000000",
                     {ssr, swap, gate, readout, busy, done, result});
        end
        run_seq(1, 2, 1'b1, 1'b0, -1, -1);
    endtask

`ifdef SSR_FLIP_COUNT_EN
    task automatic test_flip_count();
        do_reset();
        run_seq(0, 1, 1'b1, 1'b0, -1, -1);
        run_seq(0, 1, 1'b0, 1'b0, -1, -1);
        run_seq(0, 1, 1'b1, 1'b0, -1, -1);
        checks++;
        if (flip_count !== 16'd2) begin
            errors++;
            $display("FAIL flip_count_three_runs: got %0d expected 2", flip_count);
        end
        // n=0,w=1 gives done in cycle 12; clear pulses in that cycle.
        run_seq(0, 1, 1'b1, 1'b0, -1, 12);
        checks++;
        if (flip_count !== 16'd0) begin
            errors++;
            $display("FAIL flip_count_clear: got %0d expected 0", flip_count);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_seq(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; flip_in = 1'b0;
        n_rep = '0; window_len = '0;
`ifdef SSR_FLIP_COUNT_EN
        flip_count_clr = 1'b0;
`endif
        test_reset();
        test_directed();
        test_abort();
        test_async_reset();
`ifdef SSR_FLIP_COUNT_EN
        test_flip_count();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
